// File: rtl/mc_pkg.sv
// Shared constants and types for the motion-compensation reconstruction block.
// The default sizes here seed the parameters of mc_recon; the clamp limit is
// the largest motion-vector component that keeps the block window inside the
// reference frame.
package mc_pkg;

    localparam int MC_MB_SIZE        = 4;
    localparam int MC_PIXEL_WIDTH    = 8;
    localparam int MC_REF_FRAME_SIZE = 8;
    localparam int MC_RES_WIDTH      = MC_PIXEL_WIDTH + 1;
    localparam int MC_MV_WIDTH       = 6;
    localparam int MC_CLAMP_MAX      = MC_REF_FRAME_SIZE - MC_MB_SIZE;

    // Controller state; the encoding is visible as mc_recon.state for checkers.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        OUT  = 2'd2
    } mc_state_e;

endpackage

// File: rtl/mc_recon_row.sv
// One row of reconstruction adders: pixel + signed residual, computed one bit
// wider than the residual, then reduced back to pixel width.
// Build option MC_RECON_CLIP_EN: when defined each sum saturates to the pixel
// range; otherwise the low pixel bits are kept (modulo wrap), which exactly
// undoes an encoder that produced its residual with wrapping subtraction.
module mc_recon_row import mc_pkg::*; #(
    parameter int MB_SIZE     = MC_MB_SIZE,
    parameter int PIXEL_WIDTH = MC_PIXEL_WIDTH,
    parameter int RES_WIDTH   = PIXEL_WIDTH + 1
) (
    input  logic        [PIXEL_WIDTH-1:0] ref_row [MB_SIZE],
    input  logic signed [RES_WIDTH-1:0]   res_row [MB_SIZE],
    output logic        [PIXEL_WIDTH-1:0] sum_row [MB_SIZE]
);

    // Sum width: residual width plus one, pixel zero-extended.
    localparam int SW = RES_WIDTH + 1;

`ifdef MC_RECON_CLIP_EN
    localparam logic signed [SW-1:0] PIX_MAX = SW'((1 << PIXEL_WIDTH) - 1);

    logic signed [SW-1:0] sum_w [MB_SIZE];

    // Add each column and saturate the result into [0, 2^PIXEL_WIDTH-1].
    always_comb begin
        for (int j = 0; j < MB_SIZE; j++) begin
            sum_w[j] = signed'({{(SW-PIXEL_WIDTH){1'b0}}, ref_row[j]}) + SW'(res_row[j]);
            if (sum_w[j] < 0) begin
                sum_row[j] = '0;
            end else if (sum_w[j] > PIX_MAX) begin
                sum_row[j] = '1;
            end else begin
                sum_row[j] = sum_w[j][PIXEL_WIDTH-1:0];
            end
        end
    end
`else
    // Add each column and keep the low pixel bits of the sum.
    always_comb begin
        for (int j = 0; j < MB_SIZE; j++) begin
            sum_row[j] = PIXEL_WIDTH'(signed'({{(SW-PIXEL_WIDTH){1'b0}}, ref_row[j]})
                                      + SW'(res_row[j]));
        end
    end
`endif

endmodule

// File: rtl/mc_recon.sv
// Motion-compensated block reconstruction: recon = ref(window at clamped mv)
// + residual, one row per cycle through a single shared row adder.
// Build option MC_RECON_CLIP_EN selects saturating instead of wrapping output
// (see mc_recon_row).
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. src_ready is a register that is high only in IDLE; dst_valid rises
// with the last recon row and, together with recon and mv_clamped, holds
// steady until dst_ready is sampled high. The two sides never overlap, so a
// new block can be accepted at most every MB_SIZE+2 cycles.
module mc_recon import mc_pkg::*; #(
    parameter int MB_SIZE        = MC_MB_SIZE,
    parameter int PIXEL_WIDTH    = MC_PIXEL_WIDTH,
    parameter int REF_FRAME_SIZE = MC_REF_FRAME_SIZE,
    parameter int RES_WIDTH      = PIXEL_WIDTH + 1
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic        [MC_MV_WIDTH-1:0] mv_x,
    input  logic        [MC_MV_WIDTH-1:0] mv_y,
    input  logic        [PIXEL_WIDTH-1:0] ref_frame [REF_FRAME_SIZE][REF_FRAME_SIZE],
    input  logic signed [RES_WIDTH-1:0]   residual  [MB_SIZE][MB_SIZE],
    input  logic                          src_valid,
    output logic                          src_ready,
    output logic                          dst_valid,
    input  logic                          dst_ready,
    output logic        [PIXEL_WIDTH-1:0] recon     [MB_SIZE][MB_SIZE],
    output logic                          mv_clamped
);

    localparam int CLAMP_MAX = REF_FRAME_SIZE - MB_SIZE;
    localparam int IW        = (REF_FRAME_SIZE > 1) ? $clog2(REF_FRAME_SIZE) : 1;
    localparam int CW        = (MB_SIZE > 1) ? $clog2(MB_SIZE) : 1;
    localparam logic [CW-1:0]          ROW_LAST = CW'(MB_SIZE - 1);
    localparam logic [MC_MV_WIDTH-1:0] MV_MAX   = MC_MV_WIDTH'(CLAMP_MAX);

    mc_state_e                   state;
    logic        [CW-1:0]        row_cnt;
    logic                        clamp_x;
    logic                        clamp_y;
    logic        [IW-1:0]        mvx_c;
    logic        [IW-1:0]        mvy_c;
    logic        [PIXEL_WIDTH-1:0] win_d   [MB_SIZE][MB_SIZE];
    logic        [PIXEL_WIDTH-1:0] win_q   [MB_SIZE][MB_SIZE];
    logic signed [RES_WIDTH-1:0]   res_q   [MB_SIZE][MB_SIZE];
    logic        [PIXEL_WIDTH-1:0] ref_row [MB_SIZE];
    logic signed [RES_WIDTH-1:0]   res_row [MB_SIZE];
    logic        [PIXEL_WIDTH-1:0] sum_row [MB_SIZE];

    // Clamp each mv component so the window never leaves the reference frame.
    assign clamp_x = (mv_x > MV_MAX);
    assign clamp_y = (mv_y > MV_MAX);
    assign mvx_c   = clamp_x ? IW'(CLAMP_MAX) : IW'(mv_x);
    assign mvy_c   = clamp_y ? IW'(CLAMP_MAX) : IW'(mv_y);

    // Select the MB_SIZE x MB_SIZE reference window at the clamped offset.
    // The clamped mv is folded into this window when it is latched.
    for (genvar gi = 0; gi < MB_SIZE; gi++) begin : g_win_row
        for (genvar gj = 0; gj < MB_SIZE; gj++) begin : g_win_col
            assign win_d[gi][gj] = ref_frame[IW'(gi) + mvy_c][IW'(gj) + mvx_c];
        end
    end

    // Present the row addressed by the row counter to the shared adder row.
    always_comb begin
        for (int j = 0; j < MB_SIZE; j++) begin
            ref_row[j] = win_q[row_cnt][j];
            res_row[j] = res_q[row_cnt][j];
        end
    end

    mc_recon_row #(
        .MB_SIZE     (MB_SIZE),
        .PIXEL_WIDTH (PIXEL_WIDTH),
        .RES_WIDTH   (RES_WIDTH)
    ) u_row (
        .ref_row (ref_row),
        .res_row (res_row),
        .sum_row (sum_row)
    );

    // Controller: accept and latch in IDLE, write one row per cycle in CALC,
    // hold the finished block in OUT until the consumer takes it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            src_ready  <= 1'b0;
            dst_valid  <= 1'b0;
            mv_clamped <= 1'b0;
            row_cnt    <= '0;
            for (int i = 0; i < MB_SIZE; i++) begin
                for (int j = 0; j < MB_SIZE; j++) begin
                    recon[i][j] <= '0;
                    win_q[i][j] <= '0;
                    res_q[i][j] <= '0;
                end
            end
        end else begin
            case (state)
                IDLE: begin
                    src_ready <= 1'b1;
                    if (src_valid && src_ready) begin
                        state      <= CALC;
                        src_ready  <= 1'b0;
                        row_cnt    <= '0;
                        mv_clamped <= clamp_x | clamp_y;
                        win_q      <= win_d;
                        res_q      <= residual;
                    end
                end
                CALC: begin
                    for (int j = 0; j < MB_SIZE; j++) begin
                        recon[row_cnt][j] <= sum_row[j];
                    end
                    if (row_cnt == ROW_LAST) begin
                        state     <= OUT;
                        dst_valid <= 1'b1;
                        row_cnt   <= '0;
                    end else begin
                        row_cnt <= row_cnt + CW'(1);
                    end
                end
                OUT: begin
                    if (dst_ready) begin
                        state     <= IDLE;
                        dst_valid <= 1'b0;
                        src_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    src_ready <= 1'b0;
                    dst_valid <= 1'b0;
                    row_cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mc_recon.sv
// Directed bench for mc_recon with a block-level reference model and a
// scoreboard queue of expected output blocks.
module tb_mc_recon;

    localparam int MB    = 4;
    localparam int PW    = 8;
    localparam int RF    = 8;
    localparam int RW    = PW + 1;
    localparam int EXP_W = MB * MB * PW + 1;

`ifdef MC_RECON_CLIP_EN
    localparam int S3_EXP = 255;
    localparam int S4_EXP = 0;
    localparam int S7_EXP = 255;
`else
    localparam int S3_EXP = 4;
    localparam int S4_EXP = 252;
    localparam int S7_EXP = 254;
`endif

    logic                 clk;
    logic                 reset_n;
    logic        [5:0]    mv_x;
    logic        [5:0]    mv_y;
    logic        [PW-1:0] ref_frame [RF][RF];
    logic signed [RW-1:0] residual  [MB][MB];
    logic                 src_valid;
    logic                 src_ready;
    logic                 dst_valid;
    logic                 dst_ready;
    logic        [PW-1:0] recon     [MB][MB];
    logic                 mv_clamped;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [EXP_W-1:0] exp_q[$];
    logic [EXP_W-1:0] got_blk;

    mc_recon #(
        .MB_SIZE        (MB),
        .PIXEL_WIDTH    (PW),
        .REF_FRAME_SIZE (RF),
        .RES_WIDTH      (RW)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .mv_x       (mv_x),
        .mv_y       (mv_y),
        .ref_frame  (ref_frame),
        .residual   (residual),
        .src_valid  (src_valid),
        .src_ready  (src_ready),
        .dst_valid  (dst_valid),
        .dst_ready  (dst_ready),
        .recon      (recon),
        .mv_clamped (mv_clamped)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- model ----------------
    function automatic int reduce(input int s);
`ifdef MC_RECON_CLIP_EN
        if (s < 0) return 0;
        if (s > (1 << PW) - 1) return (1 << PW) - 1;
        return s;
`else
        return ((s % (1 << PW)) + (1 << PW)) % (1 << PW);
`endif
    endfunction

    // Expected block from the current bench-driven inputs.
    function automatic logic [EXP_W-1:0] model_block(input int mvx, input int mvy);
        logic [EXP_W-1:0] v;
        int cx;
        int cy;
        int s;
        v  = '0;
        cx = (mvx > RF - MB) ? RF - MB : mvx;
        cy = (mvy > RF - MB) ? RF - MB : mvy;
        v[EXP_W-1] = (mvx > RF - MB) || (mvy > RF - MB);
        for (int i = 0; i < MB; i++) begin
            for (int j = 0; j < MB; j++) begin
                s = int'(ref_frame[i+cy][j+cx]) + int'(residual[i][j]);
                v[(i*MB+j)*PW +: PW] = PW'(reduce(s));
            end
        end
        return v;
    endfunction

    function automatic logic [EXP_W-1:0] pack_dut();
        logic [EXP_W-1:0] v;
        v = '0;
        v[EXP_W-1] = mv_clamped;
        for (int i = 0; i < MB; i++) begin
            for (int j = 0; j < MB; j++) begin
                v[(i*MB+j)*PW +: PW] = recon[i][j];
            end
        end
        return v;
    endfunction

    function automatic int recon_or();
        int r;
        r = 0;
        for (int i = 0; i < MB; i++) begin
            for (int j = 0; j < MB; j++) begin
                r = r | int'(recon[i][j]);
            end
        end
        return r;
    endfunction

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input int act, input int exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    // Every valid output cycle is compared against the head of the queue;
    // the head retires when the consumer takes the block.
    always @(negedge clk) begin
        if (reset_n && dst_valid) begin
            got_blk = pack_dut();
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL block_unexpected: got %h expected none (t=%0t)", got_blk, $time);
            end else if (got_blk !== exp_q[0]) begin
                n_fail++;
                $display("FAIL block_data: got %h expected %h (t=%0t)", got_blk, exp_q[0], $time);
            end
            if (dst_ready && exp_q.size() > 0) begin
                void'(exp_q.pop_front());
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic fill_ref_ramp();
        for (int r = 0; r < RF; r++)
            for (int c = 0; c < RF; c++)
                ref_frame[r][c] = PW'(8 * r + c);
    endtask

    task automatic fill_ref_const(input int v);
        for (int r = 0; r < RF; r++)
            for (int c = 0; c < RF; c++)
                ref_frame[r][c] = PW'(v);
    endtask

    task automatic fill_res_const(input int v);
        for (int i = 0; i < MB; i++)
            for (int j = 0; j < MB; j++)
                residual[i][j] = RW'(v);
    endtask

    // Offer one block and wait (bounded) for it to be accepted.
    task automatic send_block(input int mvx, input int mvy);
        bit ok;
        ok   = 1'b0;
        mv_x = 6'(mvx);
        mv_y = 6'(mvy);
        exp_q.push_back(model_block(mvx, mvy));
        src_valid = 1'b1;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (src_ready) begin
                @(posedge clk);
                ok = 1'b1;
                break;
            end
        end
        #1 src_valid = 1'b0;
        check("accept", int'(ok), 1);
    endtask

    // Wait (bounded) for dst_valid; latency counted in edges after accept.
    task automatic wait_out();
        int lat;
        lat = -1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (dst_valid) begin
                lat = k;
                break;
            end
        end
        check("latency", lat, MB);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        reset_n   = 1'b0;
        src_valid = 1'b0;
        dst_ready = 1'b0;
        mv_x      = '0;
        mv_y      = '0;
        fill_ref_const(0);
        fill_res_const(0);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_src_ready", int'(src_ready), 0);
        check("rst_dst_valid", int'(dst_valid), 0);
        check("rst_mv_clamped", int'(mv_clamped), 0);
        check("rst_recon", recon_or(), 0);
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk) #1;
        check("post_rst_src_ready", int'(src_ready), 1);

        // Scenario 1: ramp frame, mv=(1,2), residual +3
        dst_ready = 1'b1;
        fill_ref_ramp();
        fill_res_const(3);
        send_block(1, 2);
        wait_out();
        for (int i = 0; i < MB; i++)
            for (int j = 0; j < MB; j++)
                check($sformatf("s1_pix_%0d_%0d", i, j), int'(recon[i][j]), 8 * (i + 2) + (j + 1) + 3);
        check("s1_mv_clamped", int'(mv_clamped), 0);
        @(posedge clk) #1;
        check("s1_dst_drop", int'(dst_valid), 0);
        check("s1_src_ready", int'(src_ready), 1);

        // Scenario 2: mv=(7,63) clamps to (4,4)
        fill_res_const(0);
        send_block(7, 63);
        wait_out();
        check("s2_pix00", int'(recon[0][0]), 36);
        check("s2_pix33", int'(recon[3][3]), 63);
        check("s2_mv_clamped", int'(mv_clamped), 1);
        @(posedge clk) #1;

        // Clamp boundary: exactly the limit is not clamped, one past is
        send_block(4, 4);
        wait_out();
        check("b44_mv_clamped", int'(mv_clamped), 0);
        check("b44_pix33", int'(recon[3][3]), 63);
        @(posedge clk) #1;
        send_block(5, 0);
        wait_out();
        check("b50_mv_clamped", int'(mv_clamped), 1);
        check("b50_pix00", int'(recon[0][0]), 4);
        @(posedge clk) #1;

        // Scenario 3: 250 + 10
        fill_ref_const(250);
        fill_res_const(10);
        send_block(0, 0);
        wait_out();
        check("s3_pix12", int'(recon[1][2]), S3_EXP);
        @(posedge clk) #1;

        // Scenario 4: 5 - 9
        fill_ref_const(5);
        fill_res_const(-9);
        send_block(2, 3);
        wait_out();
        check("s4_pix21", int'(recon[2][1]), S4_EXP);
        @(posedge clk) #1;

        // Extreme: 255 + 255
        fill_ref_const(255);
        fill_res_const(255);
        send_block(1, 1);
        wait_out();
        check("s7_pix30", int'(recon[3][0]), S7_EXP);
        @(posedge clk) #1;

        // Scenario 5: back-pressure for 10 cycles with input churn
        dst_ready = 1'b0;
        fill_ref_ramp();
        for (int i = 0; i < MB; i++)
            for (int j = 0; j < MB; j++)
                residual[i][j] = RW'(i - j);
        send_block(3, 3);
        wait_out();
        for (int n = 0; n < 10; n++) begin
            @(posedge clk) #1;
            src_valid = ~src_valid;
            mv_x = 6'(n);
            ref_frame[3][3] = PW'(n * 7);
            residual[0][0] = RW'(n);
            @(negedge clk);
            check("s5_src_ready_low", int'(src_ready), 0);
            check("s5_dst_hold", int'(dst_valid), 1);
        end
        @(posedge clk) #1;
        src_valid = 1'b0;
        dst_ready = 1'b1;
        @(posedge clk) #1;
        check("s5_dst_drop", int'(dst_valid), 0);
        check("s5_src_ready", int'(src_ready), 1);
        repeat (8) @(posedge clk);
        #1;

        // Scenario 6: reset during CALC
        fill_ref_ramp();
        fill_res_const(2);
        send_block(7, 63);
        @(posedge clk);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("s6_dst_valid", int'(dst_valid), 0);
        check("s6_src_ready", int'(src_ready), 0);
        check("s6_mv_clamped", int'(mv_clamped), 0);
        check("s6_recon", recon_or(), 0);
        exp_q.delete();
        @(negedge clk) reset_n = 1'b1;
        #1;
        check("s6_src_ready_rel", int'(src_ready), 0);
        @(posedge clk) #1;
        check("s6_src_ready_edge", int'(src_ready), 1);
        fill_res_const(1);
        send_block(2, 1);
        wait_out();
        check("s6_pix00", int'(recon[0][0]), 8 * 1 + 2 + 1);
        check("s6_pix32", int'(recon[3][2]), 8 * 4 + 4 + 1);
        check("s6_mv_clamped_next", int'(mv_clamped), 0);
        repeat (4) @(posedge clk);
        #1;

        check("exp_q_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Global time bound
    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
